// File: rtl/decode_hazard_unit.sv
// decode_hazard_unit
//   Reader-side controller for the decode->execute stage latch. Keeps a small
//   scoreboard of in-flight destinations (EX/MEM/WB), detects RAW hazards,
//   holds fetch on a hazard, squashes the wrong path after a taken branch and
//   counts stall cycles.
//   Optional feature macro: DECODE_FWD_EN
//     defined   : EX/MEM bypass selects are produced and only load-use stalls
//     undefined : no bypass, any EX/MEM producer stalls the consumer
module decode_hazard_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             br_taken,
    output logic             latch_ena,
    output logic             pc_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STALL   = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    logic [1:0]       state_r, state_nxt_s;
    logic [2:0]       cnt_r, cnt_nxt_s;
    logic [4:0]       ex_rd_r, mem_rd_r, wb_rd_r;
    logic             ex_wr_r, mem_wr_r, wb_wr_r;
    logic             ex_ld_r, mem_ld_r, wb_ld_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             m1_ex_s, m2_ex_s, m1_mem_s, m2_mem_s;
    logic             hazard_s, flush_s, issue_s;
    logic [1:0]       fwd_a_s, fwd_b_s;
    logic             unused_s;

    // A source matches a producer when it is read, written, equal and not x0.
    function automatic logic reg_match(input logic use_s, input logic [4:0] rs,
                                       input logic wr_k, input logic [4:0] rd_k);
        return use_s & wr_k & (rs == rd_k) & (rd_k != 5'd0);
    endfunction

    assign m1_ex_s  = reg_match(id_use_rs1, id_rs1, ex_wr_r,  ex_rd_r);
    assign m2_ex_s  = reg_match(id_use_rs2, id_rs2, ex_wr_r,  ex_rd_r);
    assign m1_mem_s = reg_match(id_use_rs1, id_rs1, mem_wr_r, mem_rd_r);
    assign m2_mem_s = reg_match(id_use_rs2, id_rs2, mem_wr_r, mem_rd_r);

    assign flush_s  = (state_r == ST_FLUSH);
    assign issue_s  = latch_ena;

    // WB is kept for visibility only: the regfile writes first, so it never stalls.
    assign unused_s = ^{ex_ld_r, mem_ld_r, wb_rd_r, wb_wr_r, wb_ld_r};

    // Hazard detection and bypass selection from the scoreboard.
    always_comb begin
        hazard_s = 1'b0;
        fwd_a_s  = 2'd0;
        fwd_b_s  = 2'd0;
`ifdef DECODE_FWD_EN
        hazard_s = (m1_ex_s | m2_ex_s) & ex_ld_r;
        if (m1_ex_s & ~ex_ld_r) begin
            fwd_a_s = 2'd1;
        end else if (m1_mem_s) begin
            fwd_a_s = 2'd2;
        end else begin
            fwd_a_s = 2'd0;
        end
        if (m2_ex_s & ~ex_ld_r) begin
            fwd_b_s = 2'd1;
        end else if (m2_mem_s) begin
            fwd_b_s = 2'd2;
        end else begin
            fwd_b_s = 2'd0;
        end
`else
        hazard_s = m1_ex_s | m2_ex_s | m1_mem_s | m2_mem_s;
`endif
    end

    // Latch control and bypass outputs, forced quiet while reset is asserted.
    always_comb begin
        latch_ena = 1'b0;
        pc_hold   = 1'b0;
        fwd_a     = 2'd0;
        fwd_b     = 2'd0;
        if (rst_n) begin
            latch_ena = ~flush_s & ~br_taken & ~hazard_s & id_valid;
            pc_hold   = hazard_s & ~br_taken & ~flush_s;
            fwd_a     = fwd_a_s;
            fwd_b     = fwd_b_s;
        end else begin
            latch_ena = 1'b0;
            pc_hold   = 1'b0;
            fwd_a     = 2'd0;
            fwd_b     = 2'd0;
        end
    end

    // Next-state logic: branch beats flush, flush beats hazard.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (br_taken) begin
            state_nxt_s = ST_FLUSH;
            cnt_nxt_s   = FLUSH_INIT;
        end else begin
            case (state_r)
                ST_FLUSH: begin
                    if (cnt_r != 3'd0) begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = cnt_r - 3'd1;
                    end else begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = 3'd0;
                    end
                end
                ST_RUN, ST_STALL: begin
                    state_nxt_s = hazard_s ? ST_STALL : ST_RUN;
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = 3'd0;
                end
            endcase
        end
    end

    // FSM state and flush counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Scoreboard shift: issued instruction or bubble enters EX, then MEM, WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd_r  <= 5'd0;  ex_wr_r  <= 1'b0;  ex_ld_r  <= 1'b0;
            mem_rd_r <= 5'd0;  mem_wr_r <= 1'b0;  mem_ld_r <= 1'b0;
            wb_rd_r  <= 5'd0;  wb_wr_r  <= 1'b0;  wb_ld_r  <= 1'b0;
        end else begin
            ex_rd_r  <= issue_s ? id_rd   : 5'd0;
            ex_wr_r  <= issue_s ? id_wr   : 1'b0;
            ex_ld_r  <= issue_s ? id_load : 1'b0;
            mem_rd_r <= ex_rd_r;   mem_wr_r <= ex_wr_r;   mem_ld_r <= ex_ld_r;
            wb_rd_r  <= mem_rd_r;  wb_wr_r  <= mem_wr_r;  wb_ld_r  <= mem_ld_r;
        end
    end

    // Saturating count of cycles spent holding fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (pc_hold && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign state        = state_r;
    assign stall_cycles = stall_cnt_r;

endmodule
